// File: rtl/fp32_pkg.sv
// Shared types, field widths and operand field helpers for the sequenced FP32 adder.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PINF = 32'h7F800000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_PACK,
    S_DONE
  } state_t;

  function automatic logic f_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  // Mantissa with hidden bit; exp==0 (zero or denormal) flushes to 0.
  function automatic logic [MANT_W:0] f_man(input logic [31:0] x);
    return (x[30:23] != '0) ? {1'b1, x[22:0]} : '0;
  endfunction

endpackage

// File: rtl/fp32_addsub_seq_if.sv
// Start/done handshake bundle between the calculator top level and the FP adder.
interface fp32_addsub_seq_if;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        sub;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (output start, op_a, op_b, sub, input busy, done, result);
  modport slave  (input start, op_a, op_b, sub, output busy, done, result);
endinterface

// File: rtl/fp32_align_unit.sv
// Registered exponent aligner: one right shift of the smaller-exponent mantissa
// per enabled cycle, with a saturating shift counter that flushes on overflow.
module fp32_align_unit
  import fp32_pkg::*;
#(
  parameter int MAX_ALIGN = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [EXP_W-1:0]  exp_a_in,
  input  logic [EXP_W-1:0]  exp_b_in,
  input  logic [MANT_W:0]   man_a_in,
  input  logic [MANT_W:0]   man_b_in,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W:0]   man_a,
  output logic [MANT_W:0]   man_b,
  output logic              eq
);

  localparam int CW = $clog2(MAX_ALIGN + 1);

  logic [EXP_W-1:0] ea, eb;
  logic [CW-1:0]    cnt;

  assign eq      = (ea == eb) || (cnt == CW'(MAX_ALIGN));
  assign exp_out = ea;

  // Load operands, then shift the smaller side toward the larger exponent.
  always_ff @(posedge clk) begin
    if (rst) begin
      ea    <= '0;
      eb    <= '0;
      man_a <= '0;
      man_b <= '0;
      cnt   <= '0;
    end else if (load) begin
      ea    <= exp_a_in;
      eb    <= exp_b_in;
      man_a <= man_a_in;
      man_b <= man_b_in;
      cnt   <= '0;
    end else if (en && !eq) begin
      cnt <= cnt + 1'b1;
      if (ea < eb) begin
        man_a <= man_a >> 1;
        ea    <= ea + 1'b1;
      end else begin
        man_b <= man_b >> 1;
        eb    <= eb + 1'b1;
      end
      // Last allowed shift: drop the small operand entirely and lock exponents.
      if (cnt == CW'(MAX_ALIGN - 1)) begin
        if (ea < eb) begin
          man_a <= '0;
          ea    <= eb;
        end else begin
          man_b <= '0;
          eb    <= ea;
        end
      end
    end
  end

endmodule

// File: rtl/fp32_addsub_seq.sv
// Multi-cycle binary32 add/subtract: align, add, iterative normalise, pack.
// Truncating throughout; denormals flushed; any exp==255 operand yields QNAN.
module fp32_addsub_seq
  import fp32_pkg::*;
#(
  parameter int MAX_ALIGN = 24
) (
  input  logic               clk,
  input  logic               rst,
  fp32_addsub_seq_if.slave   bus
);

  state_t state_q, state_d;

  logic              al_load, al_en, al_eq;
  logic [EXP_W-1:0]  al_exp;
  logic [MANT_W:0]   al_ma, al_mb;

  logic              sa_q, sb_q, nan_q;
  logic [MANT_W+1:0] sum_q, add_sum;
  logic              add_sign, rsign_q;
  logic [EXP_W:0]    rexp_q;
  logic [31:0]       result_q;

  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [MANT_W:0]   man_a, man_b;

  assign exp_a = f_exp(bus.op_a);
  assign exp_b = f_exp(bus.op_b);
  assign man_a = f_man(bus.op_a);
  assign man_b = f_man(bus.op_b);

  fp32_align_unit #(.MAX_ALIGN(MAX_ALIGN)) u_align (
    .clk      (clk),
    .rst      (rst),
    .load     (al_load),
    .en       (al_en),
    .exp_a_in (exp_a),
    .exp_b_in (exp_b),
    .man_a_in (man_a),
    .man_b_in (man_b),
    .exp_out  (al_exp),
    .man_a    (al_ma),
    .man_b    (al_mb),
    .eq       (al_eq)
  );

  assign bus.busy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and aligner control.
  always_comb begin
    state_d = state_q;
    al_load = 1'b0;
    al_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          al_load = 1'b1;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (nan_q)      state_d = S_PACK;
        else if (al_eq) state_d = S_ADD;
        else            al_en   = 1'b1;
      end
      S_ADD: state_d = S_NORM;
      S_NORM: begin
        if (sum_q == '0)                   state_d = S_PACK;
        else if (sum_q[MANT_W+1])          state_d = S_NORM;
        else if (sum_q[MANT_W])            state_d = S_PACK;
        else if (rexp_q <= (EXP_W+1)'(1))  state_d = S_PACK;
      end
      S_PACK: state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Signed-magnitude add of the aligned mantissas; exact cancellation gives +0.
  always_comb begin
    add_sum  = '0;
    add_sign = 1'b0;
    if (sa_q == sb_q) begin
      add_sum  = {1'b0, al_ma} + {1'b0, al_mb};
      add_sign = sa_q;
    end else if (al_ma > al_mb) begin
      add_sum  = {1'b0, al_ma} - {1'b0, al_mb};
      add_sign = sa_q;
    end else if (al_mb > al_ma) begin
      add_sum  = {1'b0, al_mb} - {1'b0, al_ma};
      add_sign = sb_q;
    end
  end

  // Datapath: operand capture, sum register, one normalise shift per cycle, pack.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      nan_q    <= 1'b0;
      sum_q    <= '0;
      rsign_q  <= 1'b0;
      rexp_q   <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            sa_q  <= f_sign(bus.op_a);
            sb_q  <= f_sign(bus.op_b) ^ bus.sub;
            nan_q <= (exp_a == '1) || (exp_b == '1);
          end
        end
        S_ADD: begin
          sum_q   <= add_sum;
          rsign_q <= add_sign;
          rexp_q  <= {1'b0, al_exp};
        end
        S_NORM: begin
          if (sum_q == '0) begin
            rsign_q <= 1'b0;
            rexp_q  <= '0;
          end else if (sum_q[MANT_W+1]) begin
            sum_q  <= sum_q >> 1;
            rexp_q <= rexp_q + 1'b1;
          end else if (sum_q[MANT_W]) begin
            // already normalised
          end else if (rexp_q <= (EXP_W+1)'(1)) begin
            // underflow: keep sign, flush magnitude
            sum_q  <= '0;
            rexp_q <= '0;
          end else begin
            sum_q  <= sum_q << 1;
            rexp_q <= rexp_q - 1'b1;
          end
        end
        S_PACK: begin
          if (nan_q)
            result_q <= QNAN;
          else if (rexp_q >= (EXP_W+1)'(255))
            result_q <= {rsign_q, PINF[30:0]};
          else
            result_q <= {rsign_q, rexp_q[EXP_W-1:0], sum_q[MANT_W-1:0]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_addsub_seq.sv
// Self-checking bench: vector table driven through a result/latency scoreboard,
// plus hand sequences for busy/DONE start suppression and mid-operation reset.
module tb_fp32_addsub_seq;

  logic clk = 1'b0;
  logic rst;

  fp32_addsub_seq_if bus();

  fp32_addsub_seq #(.MAX_ALIGN(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    int          lat;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[11];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Wait (bounded) for done, then pop the scoreboard and compare.
  task automatic wait_done();
    int   lat;
    bit   seen;
    exp_t e;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else          lat++;
    end
    e = sb.pop_front();
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=no_done required=done", e.name);
    end else begin
      chk({e.name, "_result"}, bus.result, e.res);
      chk({e.name, "_latency"}, 32'(lat), 32'(e.lat));
      chk({e.name, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    end
  endtask

  task automatic launch(input vec_t v, input int lat_from_now);
    @(negedge clk);
    bus.op_a  = v.a;
    bus.op_b  = v.b;
    bus.sub   = v.sub;
    bus.start = 1'b1;
    sb.push_back('{v.res, lat_from_now, v.name});
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  initial begin
    int ndone;
    vec_t v;

    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 5,  "one_plus_one"};
    vecs[1]  = '{32'h3F800000, 32'h3F000000, 1'b0, 32'h3FC00000, 5,  "one_plus_half"};
    vecs[2]  = '{32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 7,  "one_minus_0p75"};
    vecs[3]  = '{32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 28, "align_cap"};
    vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 5,  "overflow_inf"};
    vecs[5]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4,  "cancel_zero"};
    vecs[6]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7FC00000, 2,  "nan_a"};
    vecs[7]  = '{32'h3F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 2,  "nan_b"};
    vecs[8]  = '{32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 5,  "three_plus_neg1"};
    vecs[9]  = '{32'hBF800000, 32'hBF800000, 1'b0, 32'hC0000000, 5,  "neg_plus_neg"};
    vecs[10] = '{32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000, 5,  "one_minus_1p5"};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.sub   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy",   {31'd0, bus.busy}, 32'd0);
    chk("reset_done",   {31'd0, bus.done}, 32'd0);
    chk("reset_result", bus.result, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      launch(vecs[i], vecs[i].lat);
      wait_done();
    end

    // start pulsed while busy must not disturb the running operation.
    v = vecs[2];
    v.name = "start_while_busy";
    launch(v, 5);                // two cycles consumed below before waiting
    @(negedge clk);
    @(negedge clk);
    chk("busy_mid_op", {31'd0, bus.busy}, 32'd1);
    bus.op_a  = 32'h7F800000;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done();

    // start during DONE is ignored; result stays held in the following IDLE.
    bus.op_a  = 32'h7F800000;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("done_start_ignored_busy", {31'd0, bus.busy}, 32'd0);
    chk("result_held", bus.result, 32'h3E800000);

    // Reset during ALIGN: idle next cycle, no done, result cleared.
    launch(vecs[3], 28);
    repeat (3) @(negedge clk);
    chk("busy_in_align", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_result", bus.result, 32'd0);
    void'(sb.pop_front());
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("rst_no_done", 32'(ndone), 32'd0);

    // start coinciding with rst is dropped.
    @(negedge clk);
    bus.op_a  = 32'h3F800000;
    bus.op_b  = 32'h3F800000;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    rst       = 1'b1;
    @(posedge clk);
    #1 begin bus.start = 1'b0; rst = 1'b0; end
    @(negedge clk);
    chk("rst_beats_start", {31'd0, bus.busy}, 32'd0);

    // Normal operation after reset.
    v = vecs[0];
    v.name = "after_reset";
    launch(v, v.lat);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
